// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding, default widths and width check for the MAC sequencer
`ifndef MAC_PKG_SV
`define MAC_PKG_SV

`define MAC_CHECK_WIDTHS(dw, aw) \
    if ((aw) < 2 * (dw)) begin : g_bad_widths \
        $error("mac_dot_seq: ACC_W must be at least 2*DATA_W"); \
    end

package mac_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

`endif

// File: rtl/mac_pipe.sv
// mac_pipe: product register followed by a wrapping accumulator with a sticky carry-out flag
module mac_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_init,
    input  logic [ACC_W-1:0]  init,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf,
    output logic              busy
);
    logic [2*DATA_W-1:0] prod;
    logic                prod_valid;
    logic [ACC_W:0]      sum;

    // the extra top bit of the sum is the carry out of the accumulator
    assign sum  = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign busy = in_valid | prod_valid;

    // stage 1 registers the product, stage 2 folds it into the accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
            ovf        <= 1'b0;
        end else begin
            prod_valid <= in_valid;
            if (in_valid)
                prod <= a * b;
            if (load_init) begin
                acc <= init;
                ovf <= 1'b0;
            end else if (prod_valid) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
            end
        end
    end
endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: job sequencer streaming operand pairs through the MAC pipe, one result per job
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [ACC_W-1:0]  start_init,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              busy
);
    `MAC_CHECK_WIDTHS(DATA_W, ACC_W)

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic             pipe_busy;

    assign busy = state != IDLE;

    mac_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_init (start_valid & start_ready),
        .init      (start_init),
        .in_valid  (op_valid & op_ready),
        .a         (op_a),
        .b         (op_b),
        .acc       (res_data),
        .ovf       (res_ovf),
        .busy      (pipe_busy)
    );

    // job FSM; handshake readies and res_valid are registered alongside the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            len         <= '0;
            cnt         <= '0;
            start_ready <= 1'b1;
            op_ready    <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    len         <= start_len;
                    cnt         <= '0;
                    start_ready <= 1'b0;
                    if (start_len == '0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        state    <= RUN;
                        op_ready <= 1'b1;
                    end
                end
                RUN: if (op_valid) begin
                    cnt <= cnt + LEN_W'(1);
                    if (cnt == len - LEN_W'(1)) begin
                        state    <= DRAIN;
                        op_ready <= 1'b0;
                    end
                end
                DRAIN: if (!pipe_busy) begin
                    state     <= DONE;
                    res_valid <= 1'b1;
                end
                DONE: if (res_ready) begin
                    state       <= IDLE;
                    res_valid   <= 1'b0;
                    start_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: directed and randomized jobs checked against an arithmetic dot-product model
module tb_mac_dot_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [7:0]  start_len = '0;
    logic [15:0] start_init = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [7:0]  op_a = '0;
    logic [7:0]  op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        busy;

    int n_chk = 0;
    int n_pass = 0;
    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    mac_dot_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_len   (start_len),
        .start_init  (start_init),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic fill(input int n);
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(int'($urandom_range(0, 255)));
            qb.push_back(int'($urandom_range(0, 255)));
        end
    endtask

    task automatic wait_start_ready();
        int k = 0;
        while (!start_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("start_ready_timeout", 32'(start_ready), 32'd1);
    endtask

    // one job: reference result from plain arithmetic, then drive and check the DUT
    task automatic do_job(input int len, input int init, input int max_gap, input int bp, input bit noise);
        int acc = init;
        int ovf = 0;
        int t;
        int k;
        for (int i = 0; i < len; i++) begin
            t = acc + qa[i] * qb[i];
            if (t > 65535) ovf = 1;
            acc = t % 65536;
        end
        wait_start_ready();
        start_valid = 1'b1;
        start_len   = 8'(len);
        start_init  = 16'(init);
        @(negedge clk);
        start_valid = 1'b0;
        if (len == 0) begin
            chk("len0_res_valid", 32'(res_valid), 32'd1);
            chk("len0_op_ready", 32'(op_ready), 32'd0);
        end else begin
            for (int i = 0; i < len; i++) begin
                repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
                    op_valid = 1'b0;
                    if (noise) begin
                        start_valid = 1'($urandom_range(0, 1));
                        start_len   = 8'($urandom);
                        res_ready   = 1'($urandom_range(0, 1));
                    end
                    chk("run_start_ready", 32'(start_ready), 32'd0);
                    @(negedge clk);
                end
                op_valid = 1'b1;
                op_a = 8'(qa[i]);
                op_b = 8'(qb[i]);
                k = 0;
                while (!op_ready && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                chk("op_ready", 32'(op_ready), 32'd1);
                @(negedge clk);
            end
            op_valid    = 1'b0;
            start_valid = 1'b0;
            res_ready   = 1'b0;
            chk("lat_e0", 32'(res_valid), 32'd0);
            chk("drain_op_ready", 32'(op_ready), 32'd0);
            @(negedge clk);
            chk("lat_e1", 32'(res_valid), 32'd0);
            @(negedge clk);
            chk("lat_e2", 32'(res_valid), 32'd1);
        end
        repeat (bp) begin
            op_valid = noise;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'(acc));
            chk("hold_start_ready", 32'(start_ready), 32'd0);
            @(negedge clk);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        chk("res_data", 32'(res_data), 32'(acc));
        chk("res_ovf", 32'(res_ovf), 32'(ovf));
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_res_valid", 32'(res_valid), 32'd0);
        chk("post_start_ready", 32'(start_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_start_ready", 32'(start_ready), 32'd1);
        chk("rel_res_data", 32'(res_data), 32'd0);
        chk("rel_res_ovf", 32'(res_ovf), 32'd0);

        qa = '{2, 4, 10};
        qb = '{3, 5, 10};
        do_job(3, 0, 0, 0, 1'b0);

        do_job(0, 'h1234, 0, 0, 1'b0);

        qa = '{255, 1};
        qb = '{255, 1};
        do_job(2, 'hFFF0, 0, 0, 1'b0);
        qa = '{1};
        qb = '{1};
        do_job(1, 0, 0, 0, 1'b0);

        fill(4);
        do_job(4, int'($urandom_range(0, 65535)), 3, 5, 1'b1);

        fill(4);
        wait_start_ready();
        start_valid = 1'b1;
        start_len   = 8'd4;
        start_init  = 16'h0;
        @(negedge clk);
        start_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid = 1'b1;
            op_a = 8'(qa[i]);
            op_b = 8'(qb[i]);
            @(negedge clk);
        end
        reset_n = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_op_ready", 32'(op_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_res_data", 32'(res_data), 32'd0);
        chk("mid_rst_res_ovf", 32'(res_ovf), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_start_ready", 32'(start_ready), 32'd1);
        chk("mid_rel_res_valid", 32'(res_valid), 32'd0);
        qa = '{3};
        qb = '{3};
        do_job(1, 0, 0, 0, 1'b0);

        fill(255);
        do_job(255, int'($urandom_range(0, 65535)), 1, 2, 1'b1);
        for (int j = 0; j < 20; j++) begin
            int len = int'($urandom_range(0, 255));
            fill(len);
            do_job(len, int'($urandom_range(0, 65535)), 2, int'($urandom_range(0, 4)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
